// File: rtl/rca_pkg.sv
// Shared types and sizing helpers for the nibble-serial ripple-carry adder.
package rca_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    function automatic int calc_nslice(input int width);
        return width / SLICE_W;
    endfunction

    // Index counter needs at least one bit even for a single slice.
    function automatic int calc_idx_w(input int width);
        int n;
        n = width / SLICE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rca_4_bit.sv
// Purely combinational 4-bit ripple-carry adder slice.
module rca_4_bit
    import rca_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_c,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_c
);

    logic [SLICE_W:0] w_c;

    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_c;
        for (int i = 0; i < SLICE_W; i++) begin
            o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_c = w_c[SLICE_W];
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequencer adding two WIDTH-bit operands one nibble per clock through a shared 4-bit slice.
// Optional subtract mode with signed overflow flag: define RCA_SEQ_CTRL_SUB_EN.
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] n2,
    input  logic             ci,
`ifdef RCA_SEQ_CTRL_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             pc_out
);

    localparam int NSLICE = calc_nslice(WIDTH);
    localparam int IDXW   = calc_idx_w(WIDTH);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic               r_carry;
    logic [IDXW-1:0]    r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_pc_out;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [SLICE_W-1:0] w_slice_a;
    logic [SLICE_W-1:0] w_slice_b;
    logic [SLICE_W-1:0] w_slice_s;
    logic               w_slice_c;

    assign w_slice_a = r_op_a[SLICE_W*r_idx +: SLICE_W];
    assign w_slice_b = r_op_b[SLICE_W*r_idx +: SLICE_W];
    assign w_last    = (r_idx == IDXW'(NSLICE - 1));

    rca_4_bit u_slice (
        .i_a (w_slice_a),
        .i_b (w_slice_b),
        .i_c (r_carry),
        .o_s (w_slice_s),
        .o_c (w_slice_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE accepts start just like IDLE so back-to-back requests lose no cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = StRun;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

`ifdef RCA_SEQ_CTRL_SUB_EN
    logic r_ovf;
    logic w_msb_cin;

    // Carry into the MSB recovered from the slice sum bit: s = a ^ b ^ cin.
    assign w_msb_cin = w_slice_a[SLICE_W-1] ^ w_slice_b[SLICE_W-1] ^ w_slice_s[SLICE_W-1];
    assign ovf       = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_step && w_last) begin
            r_ovf <= w_msb_cin ^ w_slice_c;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_sum    <= '0;
            r_pc_out <= 1'b0;
        end else if (w_load) begin
            r_op_a <= n1;
            r_idx  <= '0;
`ifdef RCA_SEQ_CTRL_SUB_EN
            r_op_b  <= sub ? ~n2 : n2;
            r_carry <= sub ? 1'b1 : ci;
`else
            r_op_b  <= n2;
            r_carry <= ci;
`endif
        end else if (w_step) begin
            r_sum[SLICE_W*r_idx +: SLICE_W] <= w_slice_s;
            r_carry                         <= w_slice_c;
            r_idx                           <= r_idx + IDXW'(1);
            if (w_last) begin
                r_pc_out <= w_slice_c;
            end
        end
    end

    assign sum    = r_sum;
    assign pc_out = r_pc_out;

endmodule
